// File: rtl/scalar_seq_if.sv
// Control/data bundle between a requester and the scalar_seq multiplier.
// Latency: none, wires only.
// Backpressure: none; start is only honoured while the block is idle.
interface scalar_seq_if #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5
);
  logic                              start;
  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_a;
  logic [DATA_W-1:0]                 integer_num;
  logic [2:0]                        matrix_size;
  logic                              sat_mode;
  logic                              busy;
  logic                              done;
  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] new_matrix;
  logic                              overflow_flag;
  logic                              size_error;

  modport master (
    output start, matrix_a, integer_num, matrix_size, sat_mode,
    input  busy, done, new_matrix, overflow_flag, size_error
  );

  modport slave (
    input  start, matrix_a, integer_num, matrix_size, sat_mode,
    output busy, done, new_matrix, overflow_flag, size_error
  );
endinterface

// File: rtl/scalar_seq.sv
// Multiplies an n x n signed matrix by a signed scalar, LANES elements per cycle.
// Latency: ceil(n*n/LANES) RUN cycles, done pulses the cycle after; illegal n -> done next cycle.
// Backpressure: start is ignored while busy; results hold until the next accepted start.
module scalar_seq #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5,
  parameter int LANES   = 1
) (
  input  logic        clk,
  input  logic        reset,
  scalar_seq_if.slave bus
);
  localparam int TOTAL = MAX_DIM * MAX_DIM;
  localparam int VEC_W = TOTAL * DATA_W;
  localparam int IDX_W = $clog2(TOTAL + LANES + 1);
  localparam logic [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state;
  logic [VEC_W-1:0]          a_q;
  logic [VEC_W-1:0]          mat_q;
  logic [VEC_W-1:0]          mat_nxt;
  logic signed [DATA_W-1:0]  k_q;
  logic                      sat_q;
  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          nn;
  logic                      busy_q;
  logic                      done_q;
  logic                      ovf_q;
  logic                      se_q;
  logic                      ovf_grp;
  logic                      size_ok;
  logic                      last_grp;

  int                        e;
  logic signed [DATA_W-1:0]  el;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]         res;
  logic                      ovf_e;

  assign size_ok  = (int'(bus.matrix_size) >= 2) && (int'(bus.matrix_size) <= MAX_DIM);
  assign last_grp = ((idx + IDX_W'(LANES)) >= nn);

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.new_matrix    = mat_q;
  assign bus.overflow_flag = ovf_q;
  assign bus.size_error    = se_q;

  // Compute this cycle's lane group; lanes past n*n keep their cleared zero value.
  always_comb begin
    mat_nxt = mat_q;
    ovf_grp = 1'b0;
    e       = 0;
    el      = '0;
    prod    = '0;
    res     = '0;
    ovf_e   = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      e = int'(idx) + l;
      if (e < int'(nn)) begin
        el    = signed'(a_q[e*DATA_W +: DATA_W]);
        prod  = el * k_q;
        // In range only when the top DATA_W+1 bits are all sign copies.
        ovf_e = ~((&prod[2*DATA_W-1:DATA_W-1]) | ~(|prod[2*DATA_W-1:DATA_W-1]));
        if (ovf_e && sat_q) res = prod[2*DATA_W-1] ? MINV : MAXV;
        else                res = prod[DATA_W-1:0];
        mat_nxt[e*DATA_W +: DATA_W] = res;
        ovf_grp = ovf_grp | ovf_e;
      end
    end
  end

  // Control FSM with registered status outputs and result accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      mat_q  <= '0;
      k_q    <= '0;
      sat_q  <= 1'b0;
      idx    <= '0;
      nn     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      se_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q    <= bus.matrix_a;
            k_q    <= signed'(bus.integer_num);
            sat_q  <= bus.sat_mode;
            nn     <= IDX_W'(bus.matrix_size) * IDX_W'(bus.matrix_size);
            idx    <= '0;
            mat_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (size_ok) begin
              se_q  <= 1'b0;
              state <= RUN;
            end else begin
              se_q   <= 1'b1;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        RUN: begin
          mat_q <= mat_nxt;
          ovf_q <= ovf_q | ovf_grp;
          idx   <= idx + IDX_W'(LANES);
          if (last_grp) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/scalar_seq.md
SCALAR_SEQ -- requirements
Module: scalar_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed element and scalar width in bits.
REQ-002 SHALL have parameter MAX_DIM, default 5: largest square matrix dimension supported.
REQ-003 SHALL have parameter LANES, default 1: number of elements processed per RUN cycle, legal range 1..MAX_DIM*MAX_DIM.
REQ-004 SHALL have port clk  input  1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1: request a new operation; sampled only in IDLE.
REQ-007 SHALL have port matrix_a  input  MAX_DIM*MAX_DIM*DATA_W: row-major elements, element i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port integer_num  input  DATA_W: signed scalar multiplier.
REQ-009 SHALL have port matrix_size  input  3: dimension n; legal values are 2..MAX_DIM.
REQ-010 SHALL have port sat_mode  input  1: 0 = wrap the result, 1 = saturate the result.
REQ-011 SHALL have port busy  output  1: high in RUN and DONE.
REQ-012 SHALL have port done  output  1: one-cycle completion pulse.
REQ-013 SHALL have port new_matrix  output  MAX_DIM*MAX_DIM*DATA_W: result, using the same packing as matrix_a.
REQ-014 SHALL have port overflow_flag  output  1: at least one active product exceeded DATA_W signed range.
REQ-015 SHALL have port size_error  output  1: the last accepted matrix_size was illegal.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN and DONE.
- IDLE -> RUN on start=1 with legal n.
- IDLE -> DONE on start=1 with illegal n.
- RUN -> DONE after the last lane group.
- DONE -> IDLE unconditionally.
REQ-017 On start acceptance, the block SHALL:
- latch matrix_a, integer_num, n and sat_mode;
- clear new_matrix, overflow_flag and size_error;
- set the element index to 0.
REQ-018 start SHALL be ignored in RUN and DONE; input changes after acceptance SHALL NOT affect the operation in progress.
REQ-019 Each RUN cycle SHALL process elements idx..idx+LANES-1, write their results to new_matrix, then advance idx by LANES.
REQ-020 RUN SHALL last exactly ceil(n*n/LANES) cycles; elements idx >= n*n within the final group SHALL be written 0 and SHALL NOT affect overflow_flag.
REQ-021 Each product SHALL be computed as a full 2*DATA_W-bit signed product of the element and integer_num.
REQ-022 overflow SHALL be flagged when the product lies outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-023 With sat_mode=0, the stored result SHALL be the low DATA_W bits of the product.
REQ-024 With sat_mode=1, the stored result SHALL be clamped to 2^(DATA_W-1)-1 or -2^(DATA_W-1) on overflow, and SHALL otherwise be the exact product.
REQ-025 overflow_flag SHALL be sticky from the first overflowing active element until the next start acceptance, and SHALL be valid when done=1.
REQ-026 Elements with index >= n*n SHALL read as 0 in new_matrix at done.
REQ-027 done SHALL be high exactly one cycle, in DONE.
- Legal n: the (ceil(n*n/LANES)+1)-th cycle after the accepting edge.
- Illegal n: the cycle after the accepting edge, with size_error=1 and new_matrix all zeros.
REQ-028 new_matrix, overflow_flag and size_error SHALL hold their values after DONE until the next start acceptance.
REQ-029 start=1 held continuously SHALL begin a new operation from IDLE; the earliest acceptance is the cycle after DONE.

Reset
REQ-030 reset=1 SHALL immediately, asynchronously of clk, force the following:
- state=IDLE, idx=0;
- busy=0, done=0;
- new_matrix=0, overflow_flag=0, size_error=0.
REQ-031 A reset asserted mid-RUN SHALL abort the operation with no partial result retained; start SHALL be acceptable on the first clock edge after reset deasserts.

Verification (DATA_W=8, MAX_DIM=5)
REQ-032 LANES=1, n=2, a=[1,2,3,4], scalar=3, wrap -> new_matrix=[3,6,9,12,0...], overflow_flag=0, done 5 cycles after start.
REQ-033 n=3, all elements 100, scalar=2 -> with wrap, all 9 results 0xC8 (-56); with sat, all 127; overflow_flag=1 in both cases, remaining 16 elements 0.
REQ-034 n=2, a=[-128,-128,5,-7], scalar=-1, sat -> [127,127,-5,7], overflow_flag=1.
REQ-035 n=2, a=[-128,-128,5,-7], scalar=-128, wrap -> [0,0,0x80,0x80], overflow_flag=1.
REQ-036 LANES=4, n=5 -> exactly 7 RUN cycles, done on cycle 8, element 24 correct, no spurious overflow from padded lanes.
REQ-037 Reset pulse in the 2nd RUN cycle -> all outputs 0 and IDLE immediately.
REQ-038 start pulsed while busy -> ignored.
REQ-039 matrix_size=6 or 1 -> done the next cycle with size_error=1 and new_matrix=0.
